// File: rtl/panda_srgate_force_sched_if.sv
// rtl/panda_srgate_force_sched_if.sv - command handshake bundle for the srgate force scheduler
interface panda_srgate_force_sched_if #(
  parameter int IDXW = 2,
  parameter int DW   = 16
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic [IDXW-1:0] cmd_gate;
  logic            cmd_op;
  logic [DW-1:0]   cmd_delay;

  modport master (output cmd_valid, cmd_gate, cmd_op, cmd_delay, input cmd_ready);
  modport slave  (input cmd_valid, cmd_gate, cmd_op, cmd_delay, output cmd_ready);
endinterface

// File: rtl/panda_srgate_force_sched.sv
// rtl/panda_srgate_force_sched.sv - queued, delayed FORCE_SET/FORCE_RST strobe scheduler for srgate blocks
// Optional issue timestamp output enabled by PANDA_SRGATE_FORCE_SCHED_TS_EN.
module panda_srgate_force_sched #(
  parameter int NGATE = 4,
  parameter int IDXW  = 2,
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  panda_srgate_force_sched_if.slave    cmd,
  input  logic                         abort_i,
  output logic [NGATE-1:0]             force_set_o,
  output logic [NGATE-1:0]             force_rst_o,
  output logic                         done_o,
  output logic                         busy_o,
  output logic [LW-1:0]                level_o,
`ifdef PANDA_SRGATE_FORCE_SCHED_TS_EN
  output logic [31:0]                  issue_ts_o,
`endif
  output logic                         err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [IDXW-1:0] gate;
    logic            op;
    logic [DW-1:0]   delay;
  } cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FIRE} state_t;

  cmd_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [DW-1:0]   cnt_q;
  logic [IDXW-1:0] gate_q;
  logic            op_q;
  state_t          state_q, state_d;
  logic            pop, fire, accept, full, empty, gate_ok, bad_in;
  logic [NGATE-1:0] onehot;
  cmd_t            head;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  // Ready is held low during reset so every output reads zero while reset_n_i is asserted.
  assign cmd.cmd_ready = reset_n_i && !full && !abort_i;
  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign head   = mem_q[rd_ptr_q];
  assign bad_in = (int'(cmd.cmd_gate) >= NGATE);
  assign gate_ok = (int'(gate_q) < NGATE);
  assign onehot = NGATE'(1) << gate_q;

  assign busy_o  = (state_q != ST_IDLE) || !empty;
  assign level_o = level_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (cnt_q == '0) begin
        fire    = 1'b1;
        state_d = ST_FIRE;
      end
      ST_FIRE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
      pop     = 1'b0;
      fire    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Payload storage carries no reset; occupancy and pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wr_ptr_q] <= '{gate: cmd.cmd_gate, op: cmd.cmd_op, delay: cmd.cmd_delay};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      gate_q      <= '0;
      op_q        <= 1'b0;
      force_set_o <= '0;
      force_rst_o <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else if (abort_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      force_set_o <= '0;
      force_rst_o <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(accept) - LW'(pop);
      if (pop) begin
        cnt_q  <= head.delay;
        gate_q <= head.gate;
        op_q   <= head.op;
      end else if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - DW'(1);
      end
      // Out-of-range commands keep their timing and done pulse but drive no gate.
      force_set_o <= (fire && op_q && gate_ok)  ? onehot : '0;
      force_rst_o <= (fire && !op_q && gate_ok) ? onehot : '0;
      done_o      <= fire;
      if (accept && bad_in) err_o <= 1'b1;
    end
  end

`ifdef PANDA_SRGATE_FORCE_SCHED_TS_EN
  logic [31:0] tick_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tick_q     <= '0;
      issue_ts_o <= '0;
    end else begin
      tick_q <= tick_q + 32'd1;
      if (fire) issue_ts_o <= tick_q;
    end
  end
`endif

endmodule
